// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS pipeline front end.
//               Holds the fetch FSM state encoding, the NOP bubble word and
//               the default reset program counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Instruction word used for pipeline bubbles (sll $0,$0,0)
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Default first fetch address after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential next address, 32-bit modulo (0xFFFF_FFFC wraps to 0)
    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Hold has priority over load, load
//               over bubble. A bubble clears the instruction and valid bit but
//               keeps pc_plus4 so decode sees a stable link address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Pipeline register update: hold, load a real instruction, or insert a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (i_hold) begin
            r_instr    <= r_instr;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end else if (i_bubble) begin
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction-fetch stage. Owns the PC, issues a single
//               outstanding request over a req/gnt/rvalid handshake and fills
//               the IF/ID register, inserting bubbles while memory is busy.
//               Build option FETCH_DELAY_SLOT_EN selects branch-delay-slot
//               redirect semantics; otherwise redirects squash in-flight work.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pc_srcD,
    input  logic [31:0] pc_branchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pc_plus4D,
    output logic        validD
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pcF;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_addrF;
    logic [31:0]  r_hold;
    logic         r_kill;
    logic         w_kill_nxt;

    logic         w_redir;
    logic         w_squash_en;
    logic         w_deliver_wait;
    logic         w_deliver_hold;
    logic         w_deliver;
    logic         w_load;
    logic         w_bubble;
    logic [31:0]  w_word;
    logic [31:0]  w_addr_inc;

`ifdef FETCH_DELAY_SLOT_EN
    // Delay-slot build: redirects never squash, the target waits in redir_pend
    assign w_squash_en = 1'b0;
`else
    assign w_squash_en = 1'b1;
`endif

    // Delivery and redirect qualification
    always_comb begin
        w_redir        = pc_srcD & ~stallD;
        w_deliver_wait = (r_state == WAIT) & imem_rvalid & ~r_kill & ~stallD;
        w_deliver_hold = (r_state == HOLD) & ~stallD;
        w_deliver      = w_deliver_wait | w_deliver_hold;
        w_word         = w_deliver_hold ? r_hold : imem_rdata;
        w_addr_inc     = pc_inc(r_addrF);
        w_load         = w_deliver & ~(w_redir & w_squash_en);
        w_bubble       = ~stallD & ~w_load;
    end

    // Fetch FSM next-state and kill flag
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (imem_gnt) begin
                    w_state_nxt = WAIT;
                    w_kill_nxt  = w_redir & w_squash_en;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else if (!stallD) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end else if (w_redir && w_squash_en) begin
                    w_kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (!stallD) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef FETCH_DELAY_SLOT_EN
    logic        r_pend;
    logic [31:0] r_tgt;
    logic        w_pend_nxt;
    logic [31:0] w_tgt_nxt;

    // Next PC: the delay-slot delivery steers to the (pending or fresh) target
    always_comb begin
        w_pc_nxt   = r_pcF;
        w_pend_nxt = r_pend;
        w_tgt_nxt  = r_tgt;
        if (w_deliver && !stallF) begin
            w_pend_nxt = 1'b0;
            if (w_redir) begin
                w_pc_nxt = pc_branchD;
            end else if (r_pend) begin
                w_pc_nxt = r_tgt;
            end else begin
                w_pc_nxt = w_addr_inc;
            end
        end else if (w_redir) begin
            w_pend_nxt = 1'b1;
            w_tgt_nxt  = pc_branchD;
        end
    end

    // Pending redirect target, newest redirect wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_tgt  <= 32'd0;
        end else begin
            r_pend <= w_pend_nxt;
            r_tgt  <= w_tgt_nxt;
        end
    end
`else
    // Next PC: redirect overrides sequential advance
    always_comb begin
        w_pc_nxt = r_pcF;
        if (w_redir) begin
            w_pc_nxt = pc_branchD;
        end else if (w_deliver && !stallF) begin
            w_pc_nxt = w_addr_inc;
        end
    end
`endif

    // Fetch control state, PC, outstanding address and hold buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pcF   <= RESET_PC;
            r_addrF <= RESET_PC;
            r_hold  <= NOP_INSTR;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pcF   <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
            if ((r_state == REQ) && imem_gnt) begin
                r_addrF <= r_pcF;
            end
            if ((r_state == WAIT) && imem_rvalid && !r_kill && stallD) begin
                r_hold <= imem_rdata;
            end
        end
    end

    assign imem_req  = (r_state == REQ);
    assign imem_addr = r_pcF;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_hold     (stallD),
        .i_load     (w_load),
        .i_bubble   (w_bubble),
        .i_instr    (w_word),
        .i_pc_plus4 (w_addr_inc),
        .o_instr    (instrD),
        .o_pc_plus4 (pc_plus4D),
        .o_valid    (validD)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A behavioural memory
//               answers requests with programmable grant/response delays; a
//               program-order model tracks which address must be delivered
//               next, honouring redirects (squash or delay-slot build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, pc_srcD;
    logic [31:0] pc_branchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrD, pc_plus4D;
    logic        validD;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stallF     (stallF),
        .stallD     (stallD),
        .pc_srcD    (pc_srcD),
        .pc_branchD (pc_branchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instrD     (instrD),
        .pc_plus4D  (pc_plus4D),
        .validD     (validD)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // memory model state
    logic        m_busy;
    logic [31:0] m_addr;
    int          m_rcnt, m_gcnt;
    int          g_lo, g_hi, l_lo, l_hi;
    logic        last_gnt;

    // program-order model state
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] ptgt;
    logic [31:0] prev_instr, prev_pc4;
    logic        prev_valid;
    logic [31:0] last_deliv_addr;
    logic        last_deliv;
    int          n_deliv = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h2008_0005;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_addr = 32'd0; m_rcnt = 0; m_gcnt = 0;
        exp_pc = 32'd0; pend = 1'b0; ptgt = 32'd0;
        prev_instr = 32'd0; prev_pc4 = 32'd0; prev_valid = 1'b0;
        last_gnt = 1'b0; last_deliv = 1'b0; last_deliv_addr = 32'd0;
    endtask

    // One clock: drive memory, advance, then check IF/ID against the model.
    task automatic do_cycle();
        logic        st, rd, req0, g0, r0;
        logic [31:0] tgt, addr0, a;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (m_busy && m_rcnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_addr);
        end else if (!m_busy && imem_req && m_gcnt == 0) begin
            imem_gnt = 1'b1;
        end
        st = stallD; rd = pc_srcD & ~stallD; tgt = pc_branchD;
        req0 = imem_req; addr0 = imem_addr; g0 = imem_gnt; r0 = imem_rvalid;
        @(posedge clk);
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        if (r0) begin
            m_busy = 1'b0;
            m_gcnt = $urandom_range(g_hi, g_lo);
        end else if (g0) begin
            m_busy = 1'b1; m_addr = addr0;
            m_rcnt = $urandom_range(l_hi, l_lo);
        end else begin
            if (m_busy) m_rcnt--;
            if (req0 && m_gcnt > 0) m_gcnt--;
        end
        last_gnt   = g0;
        last_deliv = 1'b0;
        if (st) begin
            check("hold_instr", instrD, prev_instr);
            check("hold_pc4", pc_plus4D, prev_pc4);
            check("hold_valid", {31'd0, validD}, {31'd0, prev_valid});
        end else begin
`ifndef FETCH_DELAY_SLOT_EN
            if (rd) check("squash_valid", {31'd0, validD}, 32'd0);
`endif
            if (!validD) check("bubble_pc4", pc_plus4D, prev_pc4);
        end
        if (rd) begin
`ifdef FETCH_DELAY_SLOT_EN
            pend = 1'b1; ptgt = tgt;
`else
            exp_pc = tgt;
`endif
        end
        if (!st && validD) begin
            a = pc_plus4D - 32'd4;
            n_deliv++;
            last_deliv = 1'b1; last_deliv_addr = a;
            check("deliv_addr", a, exp_pc);
            check("deliv_instr", instrD, mem_word(a));
            if (pend) begin
                exp_pc = ptgt; pend = 1'b0;
            end else begin
                exp_pc = pc_plus4D;
            end
        end
        if (req0 && !g0 && !rd) begin
            check("req_stable", {31'd0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, addr0);
        end
        prev_instr = instrD; prev_pc4 = pc_plus4D; prev_valid = validD;
    endtask

    task automatic wait_gnt(input string tag);
        for (int i = 0; i < 60; i++) begin
            do_cycle();
            if (last_gnt) break;
        end
        check(tag, {31'd0, last_gnt}, 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        for (int i = 0; i < 60; i++) begin
            if (imem_req) break;
            do_cycle();
        end
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, exp_addr);
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; pc_srcD = 1'b0;
        pc_branchD = 32'd0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        g_lo = 0; g_hi = 0; l_lo = 0; l_hi = 0;
        model_reset();
        repeat (3) @(negedge clk);

        // reset values
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_instr", instrD, 32'd0);
        check("rst_pc4", pc_plus4D, 32'd0);
        check("rst_valid", {31'd0, validD}, 32'd0);

        // zero-wait latency
        rst = 1'b0;
        do_cycle();
        check("lat_c1_req", {31'd0, imem_req}, 32'd1);
        check("lat_c1_addr", imem_addr, 32'd0);
        do_cycle();
        check("lat_c2_valid", {31'd0, validD}, 32'd0);
        do_cycle();
        check("lat_c3_valid", {31'd0, validD}, 32'd1);
        check("lat_c3_instr", instrD, 32'h2008_0005);
        check("lat_c3_pc4", pc_plus4D, 32'd4);

        // decode stall across the response
        wait_gnt("hold_gnt");
        stallD = 1'b1; stallF = 1'b1;
        repeat (3) do_cycle();
        stallD = 1'b0; stallF = 1'b0;
        do_cycle();
        check("hold_release_valid", {31'd0, validD}, 32'd1);
        check("hold_next_addr", imem_addr, pc_plus4D);

        // grant delayed by 4 cycles
        g_lo = 4; g_hi = 4;
        wait_gnt("dly_gnt");
        g_lo = 0; g_hi = 0;

        // redirect while a fetch is outstanding
        l_lo = 2; l_hi = 2;
        wait_gnt("redir_gnt");
        pc_srcD = 1'b1; pc_branchD = 32'h0000_0100;
        do_cycle();
        pc_srcD = 1'b0;
        l_lo = 0; l_hi = 0;
        do_cycle();
        wait_req("redir", 32'h0000_0100);

        // wrap at the top of the address space
        pc_srcD = 1'b1; pc_branchD = 32'hFFFF_FFFC;
        do_cycle();
        pc_srcD = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (last_deliv && last_deliv_addr == 32'hFFFF_FFFC) break;
            do_cycle();
        end
        check("wrap_seen", last_deliv_addr, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4D, 32'd0);
        check("wrap_next_addr", imem_addr, 32'd0);

        // asynchronous reset with a fetch in flight, then a stray response
        l_lo = 3; l_hi = 3;
        wait_gnt("arst_gnt");
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, validD}, 32'd0);
        check("arst_instr", instrD, 32'd0);
        check("arst_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        l_lo = 0; l_hi = 3; g_lo = 0; g_hi = 3;
        m_busy = 1'b1; m_rcnt = 0; m_addr = 32'h0000_0055;
        do_cycle();
        check("stray_valid", {31'd0, validD}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            stallD     = ($urandom_range(99, 0) < 20);
            stallF     = stallD;
            pc_srcD    = ($urandom_range(99, 0) < 6);
            pc_branchD = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            if ($urandom_range(9, 0) == 0) pc_branchD = 32'hFFFF_FFF8;
            do_cycle();
        end
        stallD = 1'b0; stallF = 1'b0; pc_srcD = 1'b0;
        repeat (20) do_cycle();
        check("progress", {31'd0, (n_deliv >= 150)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, issues one instruction-memory request at a time over a request/grant/response handshake, and loads the IF/ID pipeline register consumed by decode. It obeys `stallF`/`stallD` from the hazard unit and accepts branch/jump redirects resolved in decode. While memory has not yet returned an instruction, it inserts bubbles into decode rather than stalling the back end.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stallF` in 1: hold PC (from hazard unit).
- `stallD` in 1: hold IF/ID (from hazard unit).
- `pc_srcD` in 1: taken branch/jump resolved in decode.
- `pc_branchD` in 32: redirect target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; sampled by memory only in the `imem_gnt` cycle.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: instruction word.
- `instrD` out 32: IF/ID instruction; a bubble is 32'h0 (NOP).
- `pc_plus4D` out 32: fetch address of `instrD` + 4.
- `validD` out 1: `instrD` is a real instruction.

## Operation
- Registers:
  - `pcF`: next fetch address.
  - `addrF`: address of the outstanding fetch.
  - A one-entry hold buffer.
  - `kill` flag.
  - `redir_pend` flag plus target; these exist only with `DELAY_SLOT_EN`.
- FSM states: `IDLE`, `REQ`, `WAIT`, `HOLD`.
  - `IDLE`: reset state; moves to `REQ` unconditionally.
  - `REQ`: `imem_req`=1, `imem_addr`=`pcF`. On `imem_gnt`, latch `addrF`=`pcF` and go to `WAIT`. `stallF` does not suppress the request.
  - `WAIT`: on `imem_rvalid`:
    - If `kill` is set: drop the data, clear `kill`, go to `REQ`.
    - Else if `!stallD`: deliver and go to `REQ`.
    - Else: capture into the hold buffer and go to `HOLD`.
  - `HOLD`: when `!stallD`, deliver from the buffer and go to `REQ`.
- Deliver means, at the clock edge:
  - `instrD`←word, `pc_plus4D`←`addrF`+4, `validD`←1.
  - `pcF`←`addrF`+4, unless a redirect applies.
- When `!stallD` and nothing is delivered, IF/ID loads a bubble: `instrD`=0, `validD`=0, `pc_plus4D` unchanged.
- When `stallD`=1, IF/ID holds its value. When `stallF`=1, `pcF` holds, except for `addrF` latching.
- Redirect: `pc_srcD`=1 is honoured only when `stallD`=0. Without `DELAY_SLOT_EN`:
  - `pcF`←`pc_branchD`.
  - An instruction delivered in the same cycle is squashed (IF/ID gets a bubble).
  - In `WAIT`, set `kill`.
  - In `HOLD`, discard the buffer and go to `REQ`.
  - In `REQ` without grant, the address changes next cycle.
  - In `REQ` with grant in the same cycle, go to `WAIT` with `kill` set.
- Arithmetic: +4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. The low two address bits are passed through unchecked.
- Reset mid-fetch: all state clears immediately. A response arriving after reset release without a preceding grant is ignored.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instrD`=0, `pc_plus4D`=0, `validD`=0.
  - State `IDLE`; `pcF`=`RESET_PC`; `kill`=0.
- Memory contract: at most one outstanding request. `imem_rvalid` arrives no earlier than the cycle after `imem_gnt`.
- Latency with zero-wait memory (gnt in the `REQ` cycle, rvalid the next cycle):
  - First `imem_req` in the 1st cycle after reset release.
  - First `validD`=1 in the 3rd cycle.
- Throughput: one instruction per 2 cycles (`REQ`/`WAIT` alternate).
- All outputs are registered except `imem_req`/`imem_addr`, which decode from state and `pcF`.

## Configuration
- `FETCH_DELAY_SLOT_EN`, defined (MIPS branch delay slot):
  - A redirect does not squash or kill.
  - The first instruction delivered at or after the redirect cycle is the delay slot and is kept.
  - At that delivery, `pcF`←target instead of `addrF`+4. Until then the target sits in `redir_pend`.
  - A second redirect while one is pending overwrites the pending target.
- Undefined: squash semantics exactly as in Operation; no `redir_pend` logic is generated.

## Structure
- Shared package `mips_pkg`:
  - `fetch_state_t` enum.
  - `NOP_INSTR` (32'h0).
  - Default `RESET_PC` constant.
- One sub-module, `if_id_reg`: the IF/ID register with load, hold (`stallD`) and bubble inputs, and async-high reset.

## Test plan
- Reset release, zero-wait memory returning 32'h2008_0005 at address 0 → `imem_req` in cycle 1 with addr 0; `instrD`=32'h2008_0005, `pc_plus4D`=4, `validD`=1 in cycle 3.
- `stallD`=1 for 3 cycles while the response arrives → FSM sits in `HOLD`; IF/ID unchanged; the word is delivered in the first cycle after `stallD` falls; `pcF` advances once.
- `imem_gnt` delayed 4 cycles → `imem_req`/`imem_addr` stable throughout; bubbles (`validD`=0) each unstalled cycle.
- Redirect to 32'h0000_0100 while in `WAIT` (no delay slot) → the returning word is dropped, `validD`=0; the next request addresses 0x100.
- Same redirect with `FETCH_DELAY_SLOT_EN` → the in-flight word is delivered with `validD`=1; the next request addresses 0x100.
- `pcF`=32'hFFFF_FFFC fetch → `pc_plus4D`=0, next address 0.
